level_shifter_down_ctrl: RTL and testbench
==========================================

Name: level_shifter_down_ctrl

Overview:
Controlled high-to-low voltage crossing for a WIDTH-bit valid/ready stream. It sits on the low-V side of a high-V to low-V domain boundary and sequences the analog shifter enable against both supply power-good flags. It clamps outputs while the path is unpowered or settling. It buffers one beat and drains or discards it cleanly when power is lost.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
SETTLE_CYCLES, 4, cycles ls_enable must be high before traffic is accepted (>=1)
CLAMP_VAL, 0, value driven on out_data whenever the path is not ACTIVE/DRAIN

Ports:
clk  input  1  single clock for the block
rst  input  1  synchronous reset, active-high
src_pwr_good  input  1  high-V source domain supply stable
dst_pwr_good  input  1  low-V destination domain supply stable
in_valid  input  1  source beat valid (high-V domain)
in_data  input  WIDTH  source beat data
in_ready  output  1  block can accept a beat
out_valid  output  1  destination beat valid (low-V domain)
out_data  output  WIDTH  destination beat data; CLAMP_VAL when not passing data
out_ready  input  1  destination accepts beat
ls_enable  output  1  enable to analog shifter cells
path_active  output  1  high in ACTIVE only
drop_pulse  output  1  one-cycle pulse when a buffered beat is discarded

Behaviour:
- All outputs are registered, except in_ready, which is combinational from state, the buffer flag and out_ready.
- Reset (rst=1 at a clk edge): state=OFF, buffer empty, counter=0, out_valid=0, out_data=CLAMP_VAL, ls_enable=0, path_active=0, drop_pulse=0, in_ready=0. Reset overrides everything, including mid-transfer; the buffered beat is lost silently with no drop_pulse.
- pg_ok = src_pwr_good & dst_pwr_good.
- FSM states:
  - OFF: ls_enable=0, in_ready=0, out_valid=0, out_data=CLAMP_VAL. If pg_ok, go to SETTLE and load counter=SETTLE_CYCLES-1.
  - SETTLE: ls_enable=1, in_ready=0, outputs clamped. If !pg_ok, go to OFF. If counter==0, go to ACTIVE. Otherwise decrement the counter. With SETTLE_CYCLES=1, exactly one SETTLE cycle occurs.
  - ACTIVE: ls_enable=1, path_active=1, single-entry buffer.
    - in_ready = !out_valid | out_ready.
    - Accept when in_valid & in_ready. Data appears on out_data/out_valid the next cycle, so latency is 1 cycle.
    - Simultaneous consume and accept refreshes the buffer with no bubble, giving full throughput.
    - On consume without accept, out_valid drops and out_data holds its last value (not clamped).
  - DRAIN: ls_enable=1, in_ready=0, out_valid held until out_ready. On consume, go to OFF with out_data=CLAMP_VAL.
- Power loss in ACTIVE, priority dst before src:
  - dst_pwr_good=0: go to OFF next cycle. If the buffer holds an unconsumed beat (out_valid & !out_ready), clear it and pulse drop_pulse for 1 cycle. No beat is accepted in that cycle (in_ready forced 0).
  - src_pwr_good=0 with dst good: in_ready forced 0 that cycle.
    - Buffer empty, or being consumed that cycle: go to OFF.
    - Otherwise: go to DRAIN.
- Power loss in DRAIN: dst_pwr_good=0 means go to OFF, clear the buffer and pulse drop_pulse. A src_pwr_good change is ignored in DRAIN.
- A pg_ok return while in DRAIN is ignored; the power-up path always passes through OFF and then SETTLE.
- Counter width is $clog2(SETTLE_CYCLES+1) bits. There is no wrap: it only counts down from the load value to 0.
- out_data never changes while out_valid=1 and out_ready=0.

Test Plan:
1. Power-up: rst for 2 cycles, then src_pwr_good=dst_pwr_good=1, SETTLE_CYCLES=4 -> ls_enable rises 1 cycle after pg_ok; in_ready=0 for exactly 4 cycles; path_active=1 on the 5th cycle; out_data=0x00 throughout.
2. Streaming: in_valid=1, in_data=0x11,0x22,0x33 back-to-back, out_ready=1 -> out_data=0x11,0x22,0x33 on consecutive cycles, each 1 cycle after acceptance, with no bubbles.
3. Backpressure: send 0xA5 with out_ready=0 for 3 cycles -> out_valid=1 and out_data=0xA5 stable; in_ready=0. Then out_ready=1 -> consumed, and in_ready=1 in that same cycle.
4. Source loss with pending beat: buffer holds 0x5A, out_ready=0, drop src_pwr_good -> DRAIN, in_ready=0, 0x5A held. Then out_ready=1 -> consumed, next cycle OFF with ls_enable=0 and out_data=CLAMP_VAL.
5. Destination loss with pending beat: buffer holds 0x3C, drop dst_pwr_good -> drop_pulse=1 for exactly 1 cycle, out_valid=0, out_data=CLAMP_VAL, state OFF.
6. Glitch and reset: pg_ok drops at the 2nd SETTLE cycle -> OFF, and on pg_ok return the full 4-cycle settle is repeated. Separately, assert rst mid-ACTIVE with a beat buffered -> all outputs reach reset values, with drop_pulse=0.

Source files
------------

// File: rtl/level_shifter_down_ctrl.sv
// High-to-low voltage stream crossing: sequences shifter enable against both power-good flags and clamps outputs while unpowered.
// One-entry buffer, 1-cycle latency, full throughput; in_ready = !out_valid | out_ready while ACTIVE and powered.
module level_shifter_down_ctrl #(
   parameter int               WIDTH         = 8,
   parameter int               SETTLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] CLAMP_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src_pwr_good,
   input  logic             dst_pwr_good,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             ls_enable,
   output logic             path_active,
   output logic             drop_pulse
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             drop_q, drop_d;
   logic             ls_enable_q, path_active_q;
   logic             pg_ok, accept, consume;

   assign pg_ok    = src_pwr_good & dst_pwr_good;
   // Any power fault blocks acceptance in the same cycle it is seen.
   assign in_ready = (state_q == ST_ACTIVE) & pg_ok & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign consume  = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      drop_d      = 1'b0;
      case (state_q)
         ST_OFF: begin
            out_valid_d = 1'b0;
            out_data_d  = CLAMP_VAL;
            if (pg_ok) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_SETTLE: begin
            if (!pg_ok) begin
               state_d = ST_OFF;
            end else if (cnt_q == '0) begin
               state_d = ST_ACTIVE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ACTIVE: begin
            if (!dst_pwr_good) begin
               state_d     = ST_OFF;
               out_valid_d = 1'b0;
               out_data_d  = CLAMP_VAL;
               drop_d      = out_valid_q & ~out_ready;
            end else if (!src_pwr_good) begin
               if (!out_valid_q || out_ready) begin
                  state_d     = ST_OFF;
                  out_valid_d = 1'b0;
                  out_data_d  = CLAMP_VAL;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = in_data;
            end else if (consume) begin
               out_valid_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (!dst_pwr_good) begin
               state_d     = ST_OFF;
               out_valid_d = 1'b0;
               out_data_d  = CLAMP_VAL;
               drop_d      = 1'b1;
            end else if (out_ready) begin
               state_d     = ST_OFF;
               out_valid_d = 1'b0;
               out_data_d  = CLAMP_VAL;
            end
         end
         default: begin
            state_d     = ST_OFF;
            out_valid_d = 1'b0;
            out_data_d  = CLAMP_VAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_OFF;
         cnt_q         <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= CLAMP_VAL;
         drop_q        <= 1'b0;
         ls_enable_q   <= 1'b0;
         path_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         drop_q        <= drop_d;
         ls_enable_q   <= (state_d != ST_OFF);
         path_active_q <= (state_d == ST_ACTIVE);
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign drop_pulse  = drop_q;
   assign ls_enable   = ls_enable_q;
   assign path_active = path_active_q;

endmodule

// File: tb/tb_level_shifter_down_ctrl.sv
// Directed bench for level_shifter_down_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_level_shifter_down_ctrl;

   localparam int         WIDTH  = 8;
   localparam int         SETTLE = 4;
   localparam logic [7:0] CLAMP  = 8'h00;

   logic       clk = 1'b0;
   logic       rst, src_pg, dst_pg, in_valid, in_ready, out_valid, out_ready;
   logic       ls_enable, path_active, drop_pulse;
   logic [7:0] in_data, out_data;

   int checks = 0;
   int failures = 0;

   level_shifter_down_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CLAMP_VAL(CLAMP)) dut (
      .clk(clk), .rst(rst), .src_pwr_good(src_pg), .dst_pwr_good(dst_pg),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .ls_enable(ls_enable), .path_active(path_active), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: phase 0=unpowered, 1=settling, 2=passing, 3=draining; a one-slot buffer.
   int         m_phase = 0;
   int         m_left = 0;
   bit         m_full = 1'b0;
   logic [7:0] m_data = CLAMP;
   bit         m_drop = 1'b0;
   bit         m_ok = 1'b0;

   task automatic m_empty();
      m_phase = 0;
      m_full  = 1'b0;
      m_data  = CLAMP;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_empty();
         m_drop = 1'b0;
         m_ok   = 1'b1;
      end else if (m_ok) begin
         m_drop = 1'b0;
         case (m_phase)
            0: if (src_pg && dst_pg) begin m_phase = 1; m_left = SETTLE; end
            1: if (!(src_pg && dst_pg)) m_phase = 0;
               else begin m_left--; if (m_left == 0) m_phase = 2; end
            2: if (!dst_pg) begin m_drop = m_full && !out_ready; m_empty(); end
               else if (!src_pg) begin
                  if (!m_full || out_ready) m_empty(); else m_phase = 3;
               end else if (in_valid && (!m_full || out_ready)) begin
                  m_full = 1'b1; m_data = in_data;
               end else if (m_full && out_ready) m_full = 1'b0;
            default: if (!dst_pg) begin m_drop = 1'b1; m_empty(); end
                     else if (out_ready) m_empty();
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("mdl_ls_enable", ls_enable, (m_phase != 0));
         check("mdl_path_active", path_active, (m_phase == 2));
         check("mdl_out_valid", out_valid, m_full);
         check("mdl_out_data", out_data, m_data);
         check("mdl_drop_pulse", drop_pulse, m_drop);
         check("mdl_in_ready", in_ready, (m_phase == 2) && src_pg && dst_pg && (!m_full || out_ready));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; src_pg = 1'b0; dst_pg = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      cyc(2);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_ls_enable", ls_enable, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      cyc(1);

      // Power-up: 4 settle cycles, then ACTIVE
      src_pg = 1'b1; dst_pg = 1'b1;
      cyc(1);
      check("pu_ls_enable", ls_enable, 1);
      check("pu_in_ready_settle", in_ready, 0);
      cyc(3);
      check("pu_path_active_settle", path_active, 0);
      check("pu_out_data_clamped", out_data, 8'h00);
      cyc(1);
      check("pu_path_active", path_active, 1);
      check("pu_in_ready", in_ready, 1);

      // Streaming, no bubbles
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
      cyc(1); check("st_0x11", out_data, 8'h11);
      in_data = 8'h22;
      cyc(1); check("st_0x22", out_data, 8'h22);
      in_data = 8'h33;
      cyc(1); check("st_0x33", out_data, 8'h33); check("st_valid", out_valid, 1);
      in_valid = 1'b0;
      cyc(1); check("st_drop_valid", out_valid, 0); check("st_hold_data", out_data, 8'h33);

      // Backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      cyc(1);
      in_data = 8'h77; #1;
      check("bp_in_ready", in_ready, 0);
      cyc(3);
      check("bp_data_stable", out_data, 8'hA5); check("bp_valid", out_valid, 1);
      in_valid = 1'b0; out_ready = 1'b1; #1;
      check("bp_in_ready_consume", in_ready, 1);
      cyc(1); check("bp_consumed", out_valid, 0);

      // Source loss with pending beat -> DRAIN
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
      cyc(1);
      in_valid = 1'b0; src_pg = 1'b0; #1;
      check("sl_in_ready_forced", in_ready, 0);
      cyc(1);
      check("sl_drain_path", path_active, 0); check("sl_drain_ls", ls_enable, 1);
      check("sl_drain_data", out_data, 8'h5A);
      cyc(2); check("sl_drain_hold", out_valid, 1);
      out_ready = 1'b1;
      cyc(1);
      check("sl_off_ls", ls_enable, 0); check("sl_off_data", out_data, 8'h00);
      src_pg = 1'b1;
      cyc(5); check("sl_reactive", path_active, 1);

      // Destination loss with pending beat
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
      cyc(1);
      in_valid = 1'b0; dst_pg = 1'b0;
      cyc(1);
      check("dl_drop", drop_pulse, 1); check("dl_valid", out_valid, 0);
      check("dl_data", out_data, 8'h00); check("dl_ls", ls_enable, 0);
      cyc(1); check("dl_drop_once", drop_pulse, 0);

      // Glitch in 2nd settle cycle, then full re-settle
      dst_pg = 1'b1;
      cyc(2);
      src_pg = 1'b0;
      cyc(1); check("gl_off", ls_enable, 0);
      src_pg = 1'b1;
      cyc(4); check("gl_still_settle", path_active, 0);
      cyc(1); check("gl_active", path_active, 1);

      // Reset mid-ACTIVE with a buffered beat
      in_valid = 1'b1; in_data = 8'h99;
      cyc(1); check("rs_buffered", out_valid, 1);
      rst = 1'b1; in_valid = 1'b0;
      cyc(1);
      check("rs_valid", out_valid, 0); check("rs_data", out_data, 8'h00);
      check("rs_ls", ls_enable, 0); check("rs_drop", drop_pulse, 0);
      check("rs_path", path_active, 0);
      rst = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
